// File: rtl/wd_supervisor_if.sv
// wd_supervisor_if: heartbeat, control and status bundle of the motor watchdog
interface wd_supervisor_if #(parameter int N_CH = 4);
    logic            enable;
    logic [N_CH-1:0] hb_in;
    logic [N_CH-1:0] ch_mask;
    logic            fault_clr;
    logic            motor_en;
    logic            shtdwn;
    logic [N_CH-1:0] fault_ch;
    logic [1:0]      state;
    modport master (output enable, hb_in, ch_mask, fault_clr,
                    input  motor_en, shtdwn, fault_ch, state);
    modport slave  (input  enable, hb_in, ch_mask, fault_clr,
                    output motor_en, shtdwn, fault_ch, state);
endinterface

// File: rtl/wd_supervisor.sv
// wd_supervisor: multi-channel heartbeat watchdog sequencing the motor IDLE -> ARM -> RUN -> FAULT
module wd_supervisor #(
    parameter int N_CH    = 4,
    parameter int TIMEOUT = 63,
    parameter int ARM_CYC = 16,
    parameter int HOLDOFF = 250
) (
    input logic             clk_1khz,
    input logic             rst,
    wd_supervisor_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;
    localparam int CW = $clog2(TIMEOUT);
    localparam int AW = $clog2(ARM_CYC);
    localparam int HW = $clog2(HOLDOFF);

    state_t          r_state;
    logic            r_motor_en, r_shtdwn;
    logic [N_CH-1:0] r_s1, r_s2, r_prev, r_seen, r_fault_ch;
    logic [AW-1:0]   r_arm_cnt;
    logic [HW-1:0]   r_hold_cnt;
    logic [N_CH-1:0] w_edge, w_to, w_miss;

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_s1   <= '0;
            r_s2   <= '0;
            r_prev <= '0;
        end else begin
            r_s1   <= bus.hb_in;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign w_edge = r_s2 ^ r_prev;
    // an edge arriving on the final ARM cycle still counts as seen
    assign w_miss = bus.ch_mask & ~(r_seen | w_edge);

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [CW-1:0] r_cnt;
        always_ff @(posedge clk_1khz) begin
            if (rst || r_state != RUN || w_edge[i]) r_cnt <= '0;
            else if (r_cnt != CW'(TIMEOUT - 1)) r_cnt <= r_cnt + 1'b1;
        end
        assign w_to[i] = bus.ch_mask[i] & ~w_edge[i] & (r_cnt == CW'(TIMEOUT - 1));
    end

    always_ff @(posedge clk_1khz) begin
        if (rst) begin
            r_state    <= IDLE;
            r_motor_en <= 1'b0;
            r_shtdwn   <= 1'b0;
            r_fault_ch <= '0;
            r_seen     <= '0;
            r_arm_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.enable && |bus.ch_mask) begin
                        r_state   <= ARM;
                        r_seen    <= '0;
                        r_arm_cnt <= '0;
                    end
                end
                ARM: begin
                    r_seen    <= r_seen | w_edge;
                    r_arm_cnt <= r_arm_cnt + 1'b1;
                    if (!bus.enable) begin
                        r_state <= IDLE;
                    end else if (r_arm_cnt == AW'(ARM_CYC - 1)) begin
                        if (w_miss == '0) begin
                            r_state    <= RUN;
                            r_motor_en <= 1'b1;
                        end else begin
                            r_state    <= FAULT;
                            r_shtdwn   <= 1'b1;
                            r_fault_ch <= w_miss;
                            r_hold_cnt <= '0;
                        end
                    end
                end
                RUN: begin
                    if (|w_to) begin
                        r_state    <= FAULT;
                        r_motor_en <= 1'b0;
                        r_shtdwn   <= 1'b1;
                        r_fault_ch <= w_to;
                        r_hold_cnt <= '0;
                    end else if (!bus.enable) begin
                        r_state    <= IDLE;
                        r_motor_en <= 1'b0;
                    end
                end
                FAULT: begin
                    if (r_hold_cnt != HW'(HOLDOFF - 1)) begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end else if (bus.fault_clr) begin
                        r_state    <= IDLE;
                        r_shtdwn   <= 1'b0;
                        r_fault_ch <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.state    = r_state;
    assign bus.motor_en = r_motor_en;
    assign bus.shtdwn   = r_shtdwn;
    assign bus.fault_ch = r_fault_ch;
endmodule

// File: tb/tb_wd_supervisor.sv
// tb_wd_supervisor: directed scoreboard bench; expected output changes are queued with their cycle
module tb_wd_supervisor;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARM = 2'd1, S_RUN = 2'd2, S_FAULT = 2'd3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         cyc = 0;
    int         n_chk = 0;
    int         n_fail = 0;
    logic [3:0] tog_en = '0;
    int         last_tog [4];
    logic       probe = 1'b0;
    string      q_name [$];
    int         q_cyc [$];
    logic [7:0] q_val [$];
    int         c0, l, f, g, h, p, r, s;

    wd_supervisor_if #(.N_CH(4)) bus ();

    wd_supervisor #(.N_CH(4), .TIMEOUT(63), .ARM_CYC(16), .HOLDOFF(250)) dut (
        .clk_1khz (clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic expect_at(input string n, input int c, input logic [1:0] st,
                             input logic me, input logic sd, input logic [3:0] fc);
        q_name.push_back(n);
        q_cyc.push_back(c);
        q_val.push_back({st, me, sd, fc});
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    function automatic logic [7:0] outs();
        return {bus.state, bus.motor_en, bus.shtdwn, bus.fault_ch};
    endfunction

    // heartbeat generator: each enabled channel toggles every 10 cycles
    initial begin
        bus.hb_in = '0;
        for (int i = 0; i < 4; i++) last_tog[i] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 4; i++)
                if (tog_en[i] && cyc % 10 == 0) begin
                    bus.hb_in[i] = ~bus.hb_in[i];
                    last_tog[i]  = cyc;
                end
        end
    end

    initial begin
        logic [7:0] last, now, v;
        string      n;
        int         c;
        @(negedge clk);
        #2;
        last = outs();
        forever begin
            @(negedge clk);
            #2;
            now = outs();
            if (now != last || probe) begin
                probe = 1'b0;
                n_chk++;
                if (q_val.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected: outputs %b at cyc %0d, required no change", now, cyc);
                end else begin
                    n = q_name.pop_front();
                    c = q_cyc.pop_front();
                    v = q_val.pop_front();
                    if (now !== v) begin
                        n_fail++;
                        $display("FAIL %s value: {state,motor_en,shtdwn,fault_ch} got %b required %b", n, now, v);
                    end
                    n_chk++;
                    if (cyc != c) begin
                        n_fail++;
                        $display("FAIL %s cycle: got %0d required %0d", n, cyc, c);
                    end
                end
            end
            last = now;
        end
    end

    initial begin
        repeat (5000) @(posedge clk);
        $display("FAIL watchdog: bench exceeded cycle budget at cyc %0d", cyc);
        $fatal(1, "cycle budget exhausted");
    end

    initial begin
        bus.enable    = 1'b0;
        bus.ch_mask   = '0;
        bus.fault_clr = 1'b0;
        repeat (3) @(negedge clk);
        expect_at("reset", cyc, S_IDLE, 0, 0, 4'b0000);
        probe = 1'b1;
        bus.enable  = 1'b1;
        bus.ch_mask = 4'b0011;
        tog_en      = 4'b0011;
        @(negedge clk);
        c0  = cyc;
        rst = 1'b0;
        expect_at("arm1", c0 + 1, S_ARM, 0, 0, 4'b0000);
        expect_at("run1", c0 + 17, S_RUN, 1, 0, 4'b0000);

        // ch1 heartbeat loss in RUN
        wait_until(c0 + 40);
        tog_en[1] = 1'b0;
        #1;
        l = last_tog[1];
        f = l + 66;
        expect_at("to_ch1", f, S_FAULT, 0, 1, 4'b0010);

        // early clear ignored, clear at end of holdoff honoured, re-arm misses ch1
        wait_until(f + 99);
        bus.fault_clr = 1'b1;
        @(negedge clk);
        bus.fault_clr = 1'b0;
        wait_until(f + 248);
        bus.fault_clr = 1'b1;
        expect_at("clr1", f + 250, S_IDLE, 0, 0, 4'b0000);
        expect_at("rearm1", f + 251, S_ARM, 0, 0, 4'b0000);
        expect_at("arm_miss", f + 267, S_FAULT, 0, 1, 4'b0010);
        wait_until(f + 250);
        bus.fault_clr = 1'b0;

        // clear long after holdoff expired, then arm cleanly into RUN
        g = f + 267;
        wait_until(g);
        tog_en[1] = 1'b1;
        wait_until(g + 299);
        bus.fault_clr = 1'b1;
        expect_at("clr2", g + 300, S_IDLE, 0, 0, 4'b0000);
        expect_at("rearm2", g + 301, S_ARM, 0, 0, 4'b0000);
        expect_at("run2", g + 317, S_RUN, 1, 0, 4'b0000);
        wait_until(g + 300);
        bus.fault_clr = 1'b0;

        // ch0 timeout coincides with enable drop: FAULT wins
        wait_until(g + 340);
        tog_en[0] = 1'b0;
        #1;
        l = last_tog[0];
        h = l + 66;
        expect_at("to_vs_disable", h, S_FAULT, 0, 1, 4'b0001);
        wait_until(h - 1);
        bus.enable = 1'b0;

        // clear with mask=0 and enable=1: must stay IDLE
        wait_until(h + 5);
        bus.enable  = 1'b1;
        bus.ch_mask = 4'b0000;
        tog_en      = 4'b0011;
        wait_until(h + 249);
        bus.fault_clr = 1'b1;
        expect_at("clr3", h + 250, S_IDLE, 0, 0, 4'b0000);
        wait_until(h + 250);
        bus.fault_clr = 1'b0;
        wait_until(h + 270);
        expect_at("mask0_idle", cyc, S_IDLE, 0, 0, 4'b0000);
        probe = 1'b1;

        // reset in RUN, then reset in FAULT
        @(negedge clk);
        p = cyc;
        bus.ch_mask = 4'b0011;
        expect_at("arm3", p + 1, S_ARM, 0, 0, 4'b0000);
        expect_at("run3", p + 17, S_RUN, 1, 0, 4'b0000);
        wait_until(p + 30);
        r   = cyc;
        rst = 1'b1;
        expect_at("rst_run", r + 1, S_IDLE, 0, 0, 4'b0000);
        @(negedge clk);
        rst         = 1'b0;
        bus.ch_mask = 4'b0111;
        expect_at("arm4", r + 2, S_ARM, 0, 0, 4'b0000);
        expect_at("arm_miss_ch2", r + 18, S_FAULT, 0, 1, 4'b0100);
        wait_until(r + 30);
        s          = cyc;
        rst        = 1'b1;
        bus.enable = 1'b0;
        expect_at("rst_fault", s + 1, S_IDLE, 0, 0, 4'b0000);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        #3;
        n_chk++;
        if (q_val.size() != 0) begin
            n_fail++;
            $display("FAIL pending: %0d expected changes never seen, required 0 (next %s)", q_val.size(), q_name[0]);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
